// File: rtl/snake_state_regfile.sv
// rtl/snake_state_regfile.sv - snake game-state register file with read port and board-fill engine
//
// Purpose:
//   Holds NUM_CELLS small board cells and NUM_WORDS full-width state words for
//   the snake processor. All state is presented on one flat bus for the VGA
//   renderer. A registered random-access read port and a hardware fill engine
//   are included; the fill engine sweeps every cell to one value, one cell per
//   cycle, without CPU involvement.
//
// Ports:
//   clock       - single clock, all state updates on the rising edge
//   reset       - synchronous, active-high; clears all state and aborts a fill
//   enable      - write strobe for index/value_in
//   index       - write address (cells first, then words)
//   value_in    - write data; cells keep only the low CELL_BITS
//   rd_index    - read address
//   rd_data     - registered read data, cells zero-extended, 0 when out of range
//   fill_start  - single-cycle pulse that starts a board fill
//   fill_value  - value written to every cell by the fill
//   fill_busy   - fill engine active (SWEEP or DONE)
//   fill_done   - one-cycle pulse when a fill completes
//   wr_err      - one-cycle pulse, the previous cycle's write was dropped
//   value_out   - flat view of all cells followed by all words

module snake_state_regfile #(
  parameter int CELL_BITS = 2,
  parameter int NUM_CELLS = 100,
  parameter int NUM_WORDS = 8,
  parameter int WORD_BITS = 32,
  parameter int IDX_BITS  = 32
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           enable,
  input  logic [IDX_BITS-1:0]                            index,
  input  logic [WORD_BITS-1:0]                           value_in,
  input  logic [IDX_BITS-1:0]                            rd_index,
  output logic [WORD_BITS-1:0]                           rd_data,
  input  logic                                           fill_start,
  input  logic [CELL_BITS-1:0]                           fill_value,
  output logic                                           fill_busy,
  output logic                                           fill_done,
  output logic                                           wr_err,
  output logic [NUM_CELLS*CELL_BITS+NUM_WORDS*WORD_BITS-1:0] value_out
);

  localparam int NUM_ENTRIES = NUM_CELLS + NUM_WORDS;
  localparam int PTR_BITS    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } fill_state_t;

  fill_state_t           state;
  fill_state_t           next_state;
  logic [PTR_BITS-1:0]   ptr;
  logic [CELL_BITS-1:0]  fill_latch;

  logic [CELL_BITS-1:0]  cells [NUM_CELLS];
  logic [WORD_BITS-1:0]  words [NUM_WORDS];

  logic                  in_cells;
  logic                  in_range;
  logic                  cell_wr;
  logic                  word_wr;
  logic                  wr_drop;
  logic                  sweep_wr;
  logic [WORD_BITS-1:0]  rd_mux;

  // Address decode. Cell writes collide with the sweep, so they are refused
  // for the whole time the engine is busy; words are never touched by the
  // sweep and stay writable.
  always_comb begin
    in_cells = (index < IDX_BITS'(NUM_CELLS));
    in_range = (index < IDX_BITS'(NUM_ENTRIES));
    cell_wr  = enable && in_cells && !fill_busy;
    word_wr  = enable && in_range && !in_cells;
    wr_drop  = enable && (!in_range || (in_cells && fill_busy));
    sweep_wr = (state == SWEEP);
  end

  // Fill FSM state register plus sweep pointer and latched fill value.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      fill_latch <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (fill_start) begin
            ptr        <= '0;
            fill_latch <= fill_value;
          end
        end
        SWEEP: begin
          // Hold on the last cell so the pointer never wraps.
          if (ptr != LAST_PTR) begin
            ptr <= ptr + PTR_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Fill FSM next-state and outputs.
  always_comb begin
    next_state = state;
    fill_busy  = (state != IDLE);
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          next_state = SWEEP;
        end
      end
      SWEEP: begin
        if (ptr == LAST_PTR) begin
          next_state = DONE;
        end
      end
      DONE: begin
        fill_done  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Cell storage. The sweep and CPU writes never target a cell on the same
  // edge because CPU cell writes are blocked while busy; the sweep is given
  // priority anyway to keep the intent obvious.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (sweep_wr && (ptr == PTR_BITS'(i))) begin
          cells[i] <= fill_latch;
        end else if (cell_wr && (index == IDX_BITS'(i))) begin
          cells[i] <= value_in[CELL_BITS-1:0];
        end
      end
    end
  end

  // State word storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < NUM_WORDS; j++) begin
        words[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WORDS; j++) begin
        if (word_wr && (index == IDX_BITS'(NUM_CELLS + j))) begin
          words[j] <= value_in;
        end
      end
    end
  end

  // Read mux over pre-edge contents; anything unmatched reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (rd_index == IDX_BITS'(i)) begin
        rd_mux = WORD_BITS'(cells[i]);
      end
    end
    for (int j = 0; j < NUM_WORDS; j++) begin
      if (rd_index == IDX_BITS'(NUM_CELLS + j)) begin
        rd_mux = words[j];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      rd_data <= rd_mux;
      wr_err  <= wr_drop;
    end
  end

  // Flat bus: cells in the low bits, words above them.
  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell_bus
    assign value_out[CELL_BITS*g +: CELL_BITS] = cells[g];
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word_bus
    assign value_out[NUM_CELLS*CELL_BITS + WORD_BITS*g +: WORD_BITS] = words[g];
  end

endmodule

// File: tb/tb_snake_state_regfile.sv
// tb/tb_snake_state_regfile.sv - self-checking bench for snake_state_regfile

module tb_snake_state_regfile;

  localparam int CB = 2;
  localparam int NC = 100;
  localparam int NW = 8;
  localparam int WB = 32;
  localparam int IB = 32;
  localparam int VW = NC*CB + NW*WB;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [IB-1:0] index;
  logic [WB-1:0] value_in;
  logic [IB-1:0] rd_index;
  logic [WB-1:0] rd_data;
  logic          fill_start;
  logic [CB-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic          wr_err;
  logic [VW-1:0] value_out;

  snake_state_regfile #(
    .CELL_BITS(CB), .NUM_CELLS(NC), .NUM_WORDS(NW), .WORD_BITS(WB), .IDX_BITS(IB)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .index(index),
    .value_in(value_in), .rd_index(rd_index), .rd_data(rd_data),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy),
    .fill_done(fill_done), .wr_err(wr_err), .value_out(value_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays plus a fill progress counter.
  // fill_k = -1 idle, 0..NC-1 = next cell the sweep writes, NC = completion cycle.
  int          m_cells [NC];
  logic [31:0] m_words [NW];
  logic [31:0] m_rd;
  bit          m_err;
  int          fill_k;
  int          m_fv;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_bus();
    logic [VW-1:0] b;
    b = '0;
    for (int i = 0; i < NC; i++) b[CB*i +: CB] = CB'(m_cells[i]);
    for (int j = 0; j < NW; j++) b[NC*CB + WB*j +: WB] = m_words[j];
    return b;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < NC) return 32'(m_cells[a]);
    if (a < NC + NW) return m_words[a - NC];
    return 32'd0;
  endfunction

  task automatic clear_inputs();
    reset = 0; enable = 0; fill_start = 0; fill_value = 0;
    index = 0; value_in = 0; rd_index = 0;
  endtask

  // Advance the model with the current inputs, clock the DUT, compare everything.
  task automatic tick();
    bit busy;
    bit err;
    if (reset) begin
      for (int i = 0; i < NC; i++) m_cells[i] = 0;
      for (int j = 0; j < NW; j++) m_words[j] = 0;
      m_rd = 0; m_err = 0; fill_k = -1;
    end else begin
      busy = (fill_k >= 0);
      m_rd = model_read(rd_index);
      err  = enable && ((index >= NC + NW) || ((index < NC) && busy));
      m_err = err;
      if (enable && !err) begin
        if (index < NC) m_cells[index] = int'(value_in & 32'h3);
        else m_words[index - NC] = value_in;
      end
      if (fill_k == -1) begin
        if (fill_start) begin
          m_fv = int'(fill_value);
          fill_k = 0;
        end
      end else if (fill_k < NC) begin
        m_cells[fill_k] = m_fv;
        fill_k++;
      end else begin
        fill_k = -1;
      end
    end
    @(posedge clock);
    #1;
    check("rd_data", rd_data, m_rd);
    check("wr_err", wr_err, m_err);
    check("fill_busy", fill_busy, fill_k >= 0);
    check("fill_done", fill_done, fill_k == NC);
    check("value_out", value_out, model_bus());
  endtask

  task automatic run_fill_to_end(output int busy_n, output int done_n, output int done_at);
    busy_n = fill_busy ? 1 : 0;
    done_n = fill_done ? 1 : 0;
    done_at = 0;
    for (int c = 0; c < 300 && fill_busy; c++) begin
      tick();
      if (fill_busy) busy_n++;
      if (fill_done) begin
        done_n++;
        done_at = busy_n;
      end
    end
  endtask

  initial begin
    logic [VW-1:0] saved;
    logic [NC*CB-1:0] exp_cells;
    int busy_n, done_n, done_at;

    clear_inputs();
    fill_k = -1; m_rd = 0; m_err = 0; m_fv = 0;
    for (int i = 0; i < NC; i++) m_cells[i] = 0;
    for (int j = 0; j < NW; j++) m_words[j] = 0;

    // Reset state
    reset = 1;
    tick(); tick();
    reset = 0;
    check("reset_bus", value_out, '0);
    check("reset_rd", rd_data, 0);
    tick();

    // Cell write truncation, registered read, word write
    enable = 1; index = 37; value_in = 32'h7;
    tick();
    check("cell37", value_out[75:74], 2'b11);
    enable = 0; rd_index = 37;
    tick();
    check("rd_cell37", rd_data, 32'h3);
    enable = 1; index = 100; value_in = 32'hDEADBEEF;
    tick();
    enable = 0;
    check("word0", value_out[231:200], 32'hDEADBEEF);

    // Full fill timing
    fill_value = 2'b10; fill_start = 1;
    tick();
    fill_start = 0;
    run_fill_to_end(busy_n, done_n, done_at);
    check("fill_busy_cycles", busy_n, 101);
    check("fill_done_count", done_n, 1);
    check("fill_done_at", done_at, 101);
    for (int i = 0; i < NC; i++) exp_cells[CB*i +: CB] = 2'b10;
    check("fill_cells", value_out[NC*CB-1:0], exp_cells);

    // Writes and a second start during a fill
    fill_value = 2'b10; fill_start = 1;
    tick();
    fill_start = 0;
    tick(); tick(); tick();
    enable = 1; index = 5; value_in = 0;
    tick();
    check("mid_cell_err", wr_err, 1'b1);
    index = 104; value_in = 3;
    tick();
    check("mid_word_ok", wr_err, 1'b0);
    enable = 0; fill_start = 1; fill_value = 2'b01;
    tick();
    fill_start = 0;
    run_fill_to_end(busy_n, done_n, done_at);
    check("mid_done_count", done_n, 1);
    check("mid_cell5", value_out[11:10], 2'b10);
    check("mid_word4", value_out[NC*CB + 4*WB +: WB], 32'd3);
    tick();

    // Out-of-range write and read
    saved = value_out;
    enable = 1; index = 108; value_in = 32'hFF; rd_index = 200;
    tick();
    enable = 0;
    check("oor_err", wr_err, 1'b1);
    check("oor_rd", rd_data, 0);
    check("oor_bus", value_out, saved);

    // Reset mid-sweep, then a clean fill
    fill_value = 2'b11; fill_start = 1;
    tick();
    fill_start = 0;
    for (int c = 0; c < 50; c++) tick();
    reset = 1;
    tick();
    reset = 0;
    check("abort_cells", value_out[NC*CB-1:0], '0);
    check("abort_busy", fill_busy, 1'b0);
    done_n = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (fill_done) done_n++;
    end
    check("abort_no_done", done_n, 0);
    fill_value = 2'b01; fill_start = 1;
    tick();
    fill_start = 0;
    run_fill_to_end(busy_n, done_n, done_at);
    check("refill_done", done_n, 1);
    check("refill_busy", busy_n, 101);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      enable     = ($urandom_range(0, 1) == 1);
      index      = $urandom_range(0, 115);
      value_in   = $urandom;
      rd_index   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 115));
      fill_start = ($urandom_range(0, 59) == 0);
      fill_value = CB'($urandom_range(0, 3));
      tick();
    end
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
